fc_neuron_feeder: RTL
=====================

FC_NEURON_FEEDER -- requirements
Module: fc_neuron_feeder

Interface
REQ-001 Parameter: JOB_CNT_W, default 16, width of the completed-job counter.
REQ-002 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  1  byte-stream valid.
REQ-005 Port: in_ready  output  1  byte-stream ready.
REQ-006 Port: in_data  input  8  stream byte: 8 pixel bytes, then 8 weight bytes, per job.
REQ-007 Port: pooled_pixel_array  output  [7:0][7:0]  pixel vector driven to the FC neuron.
REQ-008 Port: weight  output  64  weight vector driven to the FC neuron; byte k at bits [8k+7:8k].
REQ-009 Port: neuron_result  input  8  registered result returned by the FC neuron.
REQ-010 Port: out_valid  output  1  result valid.
REQ-011 Port: out_ready  input  1  result ready.
REQ-012 Port: out_data  output  8  captured neuron result.
REQ-013 Port: job_count  output  JOB_CNT_W  number of completed jobs, modulo 2^JOB_CNT_W.

Function
REQ-014 FSM states SHALL be LOAD, SETTLE, CAPTURE and OUT; reset state SHALL be LOAD.
REQ-015 In LOAD: in_ready=1; a byte is accepted only on in_valid && in_ready; byte index idx (0..15) increments per accepted byte.
REQ-016 Accepted byte idx 0..7 SHALL be written to pooled_pixel_array[idx]; idx 8..15 SHALL be written to weight[8*(idx-8)+7 : 8*(idx-8)].
REQ-017 On acceptance of byte 15: idx returns to 0 and the FSM moves to SETTLE.
REQ-018 SETTLE SHALL last exactly 1 cycle, then move to CAPTURE. This cycle lets the neuron register its sum.
REQ-019 CAPTURE SHALL last exactly 1 cycle. On its exit edge, neuron_result is copied into out_data and the FSM moves to OUT.
REQ-020 Input-to-result latency: out_valid SHALL rise 2 cycles after the edge that accepted byte 15.
REQ-021 In OUT: out_valid=1 and out_data is held stable until out_ready=1. On that edge: move to LOAD and increment job_count.
REQ-022 job_count SHALL wrap from 2^JOB_CNT_W-1 to 0 without a flag.
REQ-023 in_ready SHALL be 0 in SETTLE, CAPTURE and OUT. Bytes presented then SHALL NOT be consumed.
REQ-024 pooled_pixel_array and weight SHALL hold their last written values in SETTLE, CAPTURE and OUT. In LOAD, only the addressed byte changes.
REQ-025 The expected result SHALL be the sum over k of pixel[k]*weight_byte[k], modulo 256, as the neuron produces it. The feeder performs no arithmetic.
REQ-026 out_ready asserted outside OUT SHALL be ignored.
REQ-027 Gaps in in_valid during LOAD SHALL stall idx with no data change.

Reset
REQ-028 While rst=1: state=LOAD, idx=0, in_ready=1, out_valid=0, out_data=0, pooled_pixel_array=0, weight=0, job_count=0.
REQ-029 Reset asserted in any state SHALL abandon the partial job. No result is emitted for it, and job_count is not incremented.
REQ-030 After rst deasserts, the next accepted byte SHALL be treated as pixel byte 0.

Verification
REQ-031 16 bytes of 0x01, out_ready=1 -> out_valid 2 cycles after byte 15, out_data=0x08, job_count=1.
REQ-032 8 pixels 0x10 and 8 weights 0x02 -> out_data=0x00 (0x100 wraps mod 256).
REQ-033 out_ready=0 for 5 cycles in OUT, with in_valid=1 meanwhile -> out_data stable, in_ready=0, no byte consumed; release -> job_count increments once, then LOAD.
REQ-034 rst pulsed after 10 bytes accepted -> all outputs return to reset values. A fresh 16-byte job (pixels 1..8, weights 0x01) -> out_data=0x24.
REQ-035 in_valid toggled every other cycle across a full job -> identical result to the back-to-back case; in_ready low only outside LOAD.
REQ-036 With JOB_CNT_W=2, run 5 jobs -> job_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/fc_neuron_feeder_if.sv
// fc_neuron_feeder_if
// Bundles the byte-stream input, the vectors presented to the FC neuron, the
// neuron result return path and the result handshake.
//   slave  : feeder side (consumes stream, drives neuron vectors and result)
//   master : environment side (drives stream and neuron result, takes result)
interface fc_neuron_feeder_if #(
    parameter int JOB_CNT_W = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [7:0]           in_data;
    logic [7:0][7:0]      pooled_pixel_array;
    logic [63:0]          weight;
    logic [7:0]           neuron_result;
    logic                 out_valid;
    logic                 out_ready;
    logic [7:0]           out_data;
    logic [JOB_CNT_W-1:0] job_count;

    modport slave (
        input  in_valid, in_data, neuron_result, out_ready,
        output in_ready, pooled_pixel_array, weight, out_valid, out_data, job_count
    );

    modport master (
        output in_valid, in_data, neuron_result, out_ready,
        input  in_ready, pooled_pixel_array, weight, out_valid, out_data, job_count
    );
endinterface

// File: rtl/fc_neuron_feeder.sv
// fc_neuron_feeder
// Collects 8 pixel bytes then 8 weight bytes from a byte stream, presents them
// to an external FC neuron, waits for the neuron's registered sum, captures it
// and offers it on a valid/ready result port. Counts completed jobs.
// Ports:
//   clk  : clock, all state on posedge
//   rst  : asynchronous active-high reset
//   bus  : fc_neuron_feeder_if.slave (stream in, neuron vectors, result out,
//          job_count)
module fc_neuron_feeder #(
    parameter int JOB_CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    fc_neuron_feeder_if.slave  bus
);
    typedef enum logic [1:0] {LOAD, SETTLE, CAPTURE, OUT} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [3:0]           r_idx;
    logic [7:0][7:0]      r_pix;
    logic [63:0]          r_wgt;
    logic [7:0]           r_out;
    logic [JOB_CNT_W-1:0] r_jobs;
    logic                 w_accept;
    logic                 w_done;

    assign w_accept = (r_state == LOAD) && bus.in_valid;
    assign w_done   = (r_state == OUT) && bus.out_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            LOAD:    if (w_accept && r_idx == 4'd15) w_next = SETTLE;
            // one cycle for the neuron to register its sum
            SETTLE:  w_next = CAPTURE;
            CAPTURE: w_next = OUT;
            OUT:     if (bus.out_ready) w_next = LOAD;
            default: w_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LOAD;
            r_idx   <= '0;
            r_pix   <= '0;
            r_wgt   <= '0;
            r_out   <= '0;
            r_jobs  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                // 4-bit index wraps 15 -> 0 at end of job
                r_idx <= r_idx + 4'd1;
                if (!r_idx[3]) r_pix[r_idx[2:0]] <= bus.in_data;
                else           r_wgt[{r_idx[2:0], 3'b000} +: 8] <= bus.in_data;
            end
            if (r_state == CAPTURE) r_out <= bus.neuron_result;
            if (w_done) r_jobs <= r_jobs + JOB_CNT_W'(1);
        end
    end

    assign bus.in_ready           = (r_state == LOAD);
    assign bus.out_valid          = (r_state == OUT);
    assign bus.out_data           = r_out;
    assign bus.pooled_pixel_array = r_pix;
    assign bus.weight             = r_wgt;
    assign bus.job_count          = r_jobs;
endmodule
